// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with load, enable, terminal value and wrap/saturate
module bcd_updown_counter #(
    parameter int DIGITS    = 2,
    parameter int MAX_VALUE = 99,
    parameter bit WRAP      = 1'b1
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  tc,
    output logic                  zero,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    logic [W-1:0] inc, dec, nxt;
    logic         carry, borrow, digits_ok, load_ok, at_max, at_zero;

    always_comb begin
        inc = bcd_out;
        dec = bcd_out;
        carry = 1'b1;
        borrow = 1'b1;
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) inc[4*i +: 4] = (bcd_out[4*i +: 4] == 4'd9) ? 4'd0 : bcd_out[4*i +: 4] + 4'd1;
            if (borrow) dec[4*i +: 4] = (bcd_out[4*i +: 4] == 4'd0) ? 4'd9 : bcd_out[4*i +: 4] - 4'd1;
            carry = carry & (bcd_out[4*i +: 4] == 4'd9);
            borrow = borrow & (bcd_out[4*i +: 4] == 4'd0);
            digits_ok = digits_ok & (load_val[4*i +: 4] <= 4'd9);
        end
    end

    // with valid digits, a plain binary compare of BCD words orders them numerically
    assign load_ok = digits_ok & (load_val <= MAX_BCD);
    assign at_max  = bcd_out == MAX_BCD;
    assign at_zero = bcd_out == '0;
    assign nxt = up ? (at_max ? (WRAP ? '0 : bcd_out) : inc)
                    : (at_zero ? (WRAP ? MAX_BCD : bcd_out) : dec);
    assign tc   = en & ~load & (up ? at_max : at_zero);
    assign zero = at_zero;

    always_ff @(posedge clk) begin
        if (init) begin
            bcd_out  <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) bcd_out <= load_val;
            load_err <= ~load_ok;
        end else begin
            load_err <= 1'b0;
            if (en) bcd_out <= nxt;
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed checks of wrap, saturate, MAX=59, load rejection, init priority and cascading
module tb_bcd_updown_counter;
    logic       clk = 1'b0;
    logic       init = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0, cen = 1'b0;
    logic [7:0] lv = 8'h00;
    logic [7:0] q0, q1, q2, cq0, cq1;
    logic       tc0, tc1, tc2, ctc0, ctc1;
    logic       z0, z1, z2, cz0, cz1;
    logic       e0, e1, e2, ce0, ce1;
    int         n = 0, bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .WRAP(1'b1)) u0 (
        .clk(clk), .init(init), .en(en), .up(up), .load(load), .load_val(lv),
        .bcd_out(q0), .tc(tc0), .zero(z0), .load_err(e0));
    bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .WRAP(1'b0)) u1 (
        .clk(clk), .init(init), .en(en), .up(up), .load(load), .load_val(lv),
        .bcd_out(q1), .tc(tc1), .zero(z1), .load_err(e1));
    bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .WRAP(1'b1)) u2 (
        .clk(clk), .init(init), .en(en), .up(up), .load(load), .load_val(lv),
        .bcd_out(q2), .tc(tc2), .zero(z2), .load_err(e2));
    bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .WRAP(1'b1)) c0 (
        .clk(clk), .init(init), .en(cen), .up(1'b1), .load(1'b0), .load_val(8'h00),
        .bcd_out(cq0), .tc(ctc0), .zero(cz0), .load_err(ce0));
    bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .WRAP(1'b1)) c1 (
        .clk(clk), .init(init), .en(ctc0), .up(1'b1), .load(1'b0), .load_val(8'h00),
        .bcd_out(cq1), .tc(ctc1), .zero(cz1), .load_err(ce1));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        tick;
        tick;
        check("rst_q", 16'(q0), 16'h00);
        check("rst_zero", 16'(z0), 16'h1);
        check("rst_tc", 16'(tc0), 16'h0);
        check("rst_err", 16'(e0), 16'h0);
        init = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            check("up_seq", 16'(q0), 16'({4'(i / 10), 4'(i % 10)}));
        end
        check("up59_q", 16'(q2), 16'h12);
        en = 1'b0; load = 1'b1; lv = 8'h98;
        tick;
        check("ld98_w", 16'(q0), 16'h98);
        check("ld98_s", 16'(q1), 16'h98);
        check("ld98_err", 16'(e0), 16'h0);
        check("ld98_59_q", 16'(q2), 16'h12);
        check("ld98_59_err", 16'(e2), 16'h1);
        load = 1'b0; en = 1'b1;
        check("tc_at98", 16'(tc0), 16'h0);
        tick;
        check("w_99", 16'(q0), 16'h99);
        check("w_tc99", 16'(tc0), 16'h1);
        check("s_tc99", 16'(tc1), 16'h1);
        check("err_clr", 16'(e2), 16'h0);
        tick;
        check("w_wrap", 16'(q0), 16'h00);
        check("s_hold", 16'(q1), 16'h99);
        check("s_tc_held", 16'(tc1), 16'h1);
        tick;
        check("w_01", 16'(q0), 16'h01);
        check("s_hold2", 16'(q1), 16'h99);
        en = 1'b0; load = 1'b1; lv = 8'h01;
        tick;
        load = 1'b0; en = 1'b1; up = 1'b0;
        check("dn_tc01", 16'(tc2), 16'h0);
        tick;
        check("dn_00", 16'(q2), 16'h00);
        check("dn_zero", 16'(z2), 16'h1);
        check("dn_tc00", 16'(tc2), 16'h1);
        tick;
        check("dn_59", 16'(q2), 16'h59);
        check("dn_99", 16'(q0), 16'h99);
        check("dn_sat0", 16'(q1), 16'h00);
        tick;
        check("dn_58", 16'(q2), 16'h58);
        check("dn_98", 16'(q0), 16'h98);
        load = 1'b1; lv = 8'h3A;
        tick;
        check("bad3A_q", 16'(q0), 16'h98);
        check("bad3A_err", 16'(e0), 16'h1);
        lv = 8'h60;
        tick;
        check("bad60_q", 16'(q2), 16'h58);
        check("bad60_err", 16'(e2), 16'h1);
        check("ok60_q", 16'(q0), 16'h60);
        check("ok60_err", 16'(e0), 16'h0);
        load = 1'b0; en = 1'b0;
        tick;
        check("err_pulse", 16'(e2), 16'h0);
        check("hold_q", 16'(q2), 16'h58);
        load = 1'b1; lv = 8'h42;
        tick;
        check("ld42", 16'(q0), 16'h42);
        init = 1'b1; en = 1'b1; lv = 8'h17;
        tick;
        check("init_wins", 16'(q0), 16'h00);
        check("init_err", 16'(e0), 16'h0);
        init = 1'b0;
        tick;
        check("ld_no_step", 16'(q0), 16'h17);
        load = 1'b0; up = 1'b1;
        tick;
        check("dir_up", 16'(q0), 16'h18);
        up = 1'b0;
        tick;
        check("dir_dn", 16'(q0), 16'h17);
        en = 1'b0;
        check("casc_start", {cq1, cq0}, 16'h0000);
        cen = 1'b1;
        for (int v = 1; v <= 9999; v++) begin
            tick;
            if (v % 100 == 0 || v == 9999) check("casc", {cq1, cq0}, bcd16(v));
        end
        check("casc_tc_hi", 16'(ctc1), 16'h1);
        tick;
        check("casc_wrap", {cq1, cq0}, 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n, bad);
        $finish;
    end
endmodule
